// File: rtl/sha256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 padder and hash core.
package sha256_pkg;

  localparam int unsigned BLOCK_BITS  = 512;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_BYTE0   = 56;
  localparam int unsigned LEN_BITS    = 64;
  localparam int unsigned IDX_W       = 6;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    S_FILL       = 3'd0,
    S_SEND       = 3'd1,
    S_SEND_SPILL = 3'd2,
    S_TAIL       = 3'd3,
    S_SEND_FINAL = 3'd4
  } pad_state_t;

  // Bit offset of the LSB of block byte k; byte 0 sits at the top of the block.
  function automatic int unsigned byte_lsb(input logic [IDX_W-1:0] k);
    return (BLOCK_BYTES - 1 - int'(k)) * 8;
  endfunction

endpackage

// File: rtl/sha256_stream_padder_if.sv
// Byte-stream input and padded-block output handshakes of the SHA-256 padder.
interface sha256_stream_padder_if;
  import sha256_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_empty;
  logic                  blk_valid;
  logic                  blk_ready;
  logic [BLOCK_BITS-1:0] blk_data;
  logic                  blk_first;
  logic                  blk_last;

  // Padder side
  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );

  // Message source / block consumer side
  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_block_buf.sv
// 64-byte block register: byte write, pad-marker write, length-field load, clear.
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_mark_en,
  input  logic [IDX_W-1:0]      i_mark_idx,
  input  logic                  i_len_en,
  input  logic [LEN_BITS-1:0]   i_len,
  output logic [BLOCK_BITS-1:0] o_data
);

  localparam int unsigned LEN_LSB_BITS = (BLOCK_BYTES - LEN_BYTE0) * 8;

  logic [BLOCK_BITS-1:0] r_buf;

  // The marker lands on the byte after the data byte, so both writes never collide.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_buf <= '0;
    end else begin
      if (i_wr_en)   r_buf[byte_lsb(i_wr_idx) +: 8]   <= i_wr_data;
      if (i_mark_en) r_buf[byte_lsb(i_mark_idx) +: 8] <= PAD_BYTE;
      if (i_len_en)  r_buf[LEN_LSB_BITS-1:0]         <= i_len;
    end
  end

  assign o_data = r_buf;

endmodule

// File: rtl/sha256_stream_padder.sv
// Packs a byte stream into FIPS 180-4 padded 512-bit blocks for the hash core.
module sha256_stream_padder
  import sha256_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input  logic                   clk,
  input  logic                   reset,
  sha256_stream_padder_if.slave  bus
);

  localparam int unsigned P_W = IDX_W + 1;

  pad_state_t         r_state, w_state_nxt;
  logic [P_W-1:0]     r_idx, w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_tail_mark, w_tail_mark_nxt;
  logic               r_first_pend, w_first_pend_nxt;

  logic               w_beat;
  logic               w_has_byte;
  logic [P_W-1:0]     w_p;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_clr;
  logic               w_wr_en;
  logic               w_mark_en;
  logic [IDX_W-1:0]   w_mark_idx;
  logic               w_len_en;
  logic [LEN_BITS-1:0] w_len;
  logic               w_sending;

  assign w_sending  = (r_state == S_SEND) || (r_state == S_SEND_SPILL) ||
                      (r_state == S_SEND_FINAL);
  assign bus.in_ready  = (r_state == S_FILL) && !reset;
  assign bus.blk_valid = w_sending;
  assign bus.blk_first = r_first_pend && w_sending;
  assign bus.blk_last  = (r_state == S_SEND_FINAL);

  assign w_beat     = bus.in_valid && bus.in_ready;
  assign w_has_byte = !bus.in_empty;
  assign w_p        = r_idx + P_W'(w_has_byte);
  assign w_cnt_inc  = r_cnt + CNT_W'(w_has_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FILL;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tail_mark  <= 1'b0;
      r_first_pend <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tail_mark  <= w_tail_mark_nxt;
      r_first_pend <= w_first_pend_nxt;
    end
  end

  // Next state plus buffer controls; length field is the bit count {bytes,3'b000}.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_tail_mark_nxt  = r_tail_mark;
    w_first_pend_nxt = r_first_pend;
    w_clr            = 1'b0;
    w_wr_en          = 1'b0;
    w_mark_en        = 1'b0;
    w_mark_idx       = w_p[IDX_W-1:0];
    w_len_en         = 1'b0;
    w_len            = LEN_BITS'({w_cnt_inc, 3'b000});

    case (r_state)
      S_FILL: begin
        if (w_beat) begin
          w_wr_en   = w_has_byte;
          w_idx_nxt = w_p;
          w_cnt_nxt = w_cnt_inc;
          if (bus.in_last) begin
            if (w_p <= P_W'(LEN_BYTE0 - 1)) begin
              w_mark_en   = 1'b1;
              w_len_en    = 1'b1;
              w_state_nxt = S_SEND_FINAL;
            end else if (w_p <= P_W'(BLOCK_BYTES - 1)) begin
              w_mark_en       = 1'b1;
              w_tail_mark_nxt = 1'b0;
              w_state_nxt     = S_SEND_SPILL;
            end else begin
              w_tail_mark_nxt = 1'b1;
              w_state_nxt     = S_SEND_SPILL;
            end
          end else if (w_p == P_W'(BLOCK_BYTES)) begin
            w_state_nxt = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (bus.blk_ready) begin
          w_clr            = 1'b1;
          w_idx_nxt        = '0;
          w_first_pend_nxt = 1'b0;
          w_state_nxt      = S_FILL;
        end
      end
      S_SEND_SPILL: begin
        if (bus.blk_ready) begin
          w_clr            = 1'b1;
          w_first_pend_nxt = 1'b0;
          w_state_nxt      = S_TAIL;
        end
      end
      S_TAIL: begin
        w_mark_en   = r_tail_mark;
        w_mark_idx  = '0;
        w_len_en    = 1'b1;
        w_len       = LEN_BITS'({r_cnt, 3'b000});
        w_state_nxt = S_SEND_FINAL;
      end
      S_SEND_FINAL: begin
        if (bus.blk_ready) begin
          w_clr            = 1'b1;
          w_idx_nxt        = '0;
          w_cnt_nxt        = '0;
          w_first_pend_nxt = 1'b1;
          w_state_nxt      = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  sha256_block_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_idx[IDX_W-1:0]),
    .i_wr_data  (bus.in_data),
    .i_mark_en  (w_mark_en),
    .i_mark_idx (w_mark_idx),
    .i_len_en   (w_len_en),
    .i_len      (w_len),
    .o_data     (bus.blk_data)
  );

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder with hand-computed padded blocks.
module tb_sha256_stream_padder;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sha256_stream_padder_if bus();

  sha256_stream_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit last, input bit empty);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 512'(bus.in_ready), 512'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic send_fill(input int n, input logic [7:0] base, input bit incr, input bit last);
    for (int i = 0; i < n; i++)
      send_beat(incr ? 8'(base + 8'(i)) : base, last && (i == n - 1), 1'b0);
  endtask

  task automatic send_abc();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
  endtask

  task automatic get_block(output logic [511:0] d, output logic f, output logic l);
    int n = 0;
    while (!bus.blk_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.blk_valid) check("blk_valid_timeout", 512'(bus.blk_valid), 512'(1));
    d = bus.blk_data;
    f = bus.blk_first;
    l = bus.blk_last;
    bus.blk_ready = 1'b1;
    tick();
    bus.blk_ready = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic [511:0] exp_d,
                             input logic exp_f, input logic exp_l);
    logic [511:0] d;
    logic f, l;
    get_block(d, f, l);
    check({tag, "_data"},  d, exp_d);
    check({tag, "_first"}, 512'(f), 512'(exp_f));
    check({tag, "_last"},  512'(l), 512'(exp_l));
  endtask

  logic [511:0] exp_abc, exp_empty, exp_55, exp_56a, exp_56b, exp_64a, exp_64b;

  initial begin
    exp_abc = '0;
    exp_abc[511:480] = 32'h61626380;
    exp_abc[63:0]    = 64'h18;
    exp_empty = '0;
    exp_empty[511:504] = 8'h80;
    exp_55 = '0;
    for (int i = 0; i < 55; i++) exp_55[511-8*i -: 8] = 8'hAA;
    exp_55[71:64] = 8'h80;
    exp_55[63:0]  = 64'h1B8;
    exp_56a = '0;
    for (int i = 0; i < 56; i++) exp_56a[511-8*i -: 8] = 8'hAA;
    exp_56a[63:56] = 8'h80;
    exp_56b = '0;
    exp_56b[63:0] = 64'h1C0;
    exp_64a = '0;
    for (int i = 0; i < 64; i++) exp_64a[511-8*i -: 8] = 8'(i);
    exp_64b = '0;
    exp_64b[511:504] = 8'h80;
    exp_64b[63:0]    = 64'h200;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.in_empty = 1'b0;
    bus.blk_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  512'(bus.in_ready),  512'(0));
    check("rst_blk_valid", 512'(bus.blk_valid), 512'(0));
    check("rst_blk_first", 512'(bus.blk_first), 512'(0));
    check("rst_blk_last",  512'(bus.blk_last),  512'(0));
    reset = 1'b0;
    tick();
    check("idle_in_ready", 512'(bus.in_ready), 512'(1));

    // "abc": blk_valid must rise right after the beat carrying 0x63
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    check("t1_no_valid_early", 512'(bus.blk_valid), 512'(0));
    send_beat(8'h63, 1'b1, 1'b0);
    check("t1_latency", 512'(bus.blk_valid), 512'(1));
    check_block("t1", exp_abc, 1'b1, 1'b1);
    check("t1_ready_after", 512'(bus.in_ready), 512'(1));

    send_beat(8'h00, 1'b1, 1'b1);
    check_block("t2", exp_empty, 1'b1, 1'b1);

    send_fill(55, 8'hAA, 1'b0, 1'b1);
    check_block("t3_55", exp_55, 1'b1, 1'b1);
    send_fill(56, 8'hAA, 1'b0, 1'b1);
    check_block("t3_56_b0", exp_56a, 1'b1, 1'b0);
    check_block("t3_56_b1", exp_56b, 1'b0, 1'b1);

    send_fill(64, 8'h00, 1'b1, 1'b1);
    check_block("t4_b0", exp_64a, 1'b1, 1'b0);
    check_block("t4_b1", exp_64b, 1'b0, 1'b1);
    send_abc();
    check_block("t4_abc", exp_abc, 1'b1, 1'b1);

    // Consumer stalls while the next message is already offered
    send_abc();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h61;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t5_stall_data%0d", i), bus.blk_data, exp_abc);
      check($sformatf("t5_stall_rdy%0d", i), 512'(bus.in_ready), 512'(0));
    end
    check("t5_stall_valid", 512'(bus.blk_valid), 512'(1));
    check_block("t5", exp_abc, 1'b1, 1'b1);
    check("t5_ready_after_hs", 512'(bus.in_ready), 512'(1));
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    check_block("t5_next", exp_abc, 1'b1, 1'b1);

    // Reset in the middle of a 100-byte message
    send_fill(30, 8'h55, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready", 512'(bus.in_ready), 512'(0));
    tick();
    reset = 1'b0;
    check("t6_blk_valid", 512'(bus.blk_valid), 512'(0));
    for (int i = 0; i < 5; i++) tick();
    check("t6_blk_valid_idle", 512'(bus.blk_valid), 512'(0));
    send_abc();
    check_block("t6_abc", exp_abc, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
